pipeline_scheduler: RTL and testbench

PIPELINE_SCHEDULER -- requirements
Module: pipeline_scheduler

---
 rtl/pipeline_scheduler.sv | 134 +++++++++++++
 tb/tb_pipeline_scheduler.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/pipeline_scheduler.sv
// Hazard/stall scheduler for a 5-stage pipeline: memory-wait freeze, branch redirect
// flushes with a one-cycle IMEM-latency squash, load-use interlock and perf counters.
module pipeline_scheduler (
  input  logic        clk,
  input  logic        rst,
  input  logic        PCSel_ei,
  input  logic        memRead_ei,
  input  logic [4:0]  rd_ei,
  input  logic [4:0]  rs1_di,
  input  logic [4:0]  rs2_di,
  input  logic        rs1Used_di,
  input  logic        rs2Used_di,
  input  logic        dmemReq_mi,
  input  logic        dmemReady_i,
  output logic        stall_F_o,
  output logic        stall_D_o,
  output logic        stall_E_o,
  output logic        stall_M_o,
  output logic        bubble_W_o,
  output logic        flush_D_o,
  output logic        flush_E_o,
  output logic        memTimeout_o,
  output logic [31:0] stallCnt_o,
  output logic [31:0] flushCnt_o
);

  typedef enum logic [1:0] {RUN, REDIRECT, MEMWAIT} state_e;

  state_e      state_q, state_d;
  state_e      resume_q, resume_d;
  state_e      eff_state;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        timeout_q, timeout_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  logic mem_stall;
  logic load_use;
  logic timeout_set;
  logic redirect_enter;
  logic st_f, st_d, st_e, st_m, bub_w, fl_d, fl_e;

  assign mem_stall = dmemReq_mi & ~dmemReady_i;
  assign load_use  = memRead_ei & (rd_ei != 5'd0) &
                     ((rs1Used_di & (rs1_di == rd_ei)) | (rs2Used_di & (rs2_di == rd_ei)));

  always_comb begin
    state_d        = state_q;
    resume_d       = resume_q;
    wait_cnt_d     = wait_cnt_q;
    timeout_set    = 1'b0;
    redirect_enter = 1'b0;
    st_f           = 1'b0;
    st_d           = 1'b0;
    st_e           = 1'b0;
    st_m           = 1'b0;
    bub_w          = 1'b0;
    fl_d           = 1'b0;
    fl_e           = 1'b0;
    // The release cycle of a wait behaves as the state that was interrupted,
    // so a deferred redirect squash lands in the first unstalled cycle.
    eff_state      = (state_q == MEMWAIT) ? resume_q : state_q;

    if (mem_stall) begin
      st_f  = 1'b1;
      st_d  = 1'b1;
      st_e  = 1'b1;
      st_m  = 1'b1;
      bub_w = 1'b1;
      if (state_q != MEMWAIT) begin
        state_d    = MEMWAIT;
        resume_d   = state_q;
        wait_cnt_d = 8'd0;
      end else begin
        if (wait_cnt_q != 8'hFF) begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
        timeout_set = (wait_cnt_q == 8'hFF);
      end
    end else if (PCSel_ei) begin
      fl_d           = 1'b1;
      fl_e           = 1'b1;
      state_d        = REDIRECT;
      redirect_enter = 1'b1;
    end else if (eff_state == REDIRECT) begin
      fl_d    = 1'b1;
      state_d = RUN;
    end else begin
      state_d = RUN;
      if (load_use) begin
        st_f = 1'b1;
        st_d = 1'b1;
        fl_e = 1'b1;
      end
    end

    timeout_d   = timeout_q | timeout_set;
    stall_cnt_d = stall_cnt_q + {31'd0, st_f};
    flush_cnt_d = flush_cnt_q + {31'd0, redirect_enter};
  end

  // Reset forces a pipeline clear and masks every other request.
  always_comb begin
    stall_F_o    = st_f & ~rst;
    stall_D_o    = st_d & ~rst;
    stall_E_o    = st_e & ~rst;
    stall_M_o    = st_m & ~rst;
    bubble_W_o   = bub_w & ~rst;
    flush_D_o    = fl_d | rst;
    flush_E_o    = fl_e | rst;
    memTimeout_o = ~rst & (timeout_q | timeout_set);
    stallCnt_o   = rst ? 32'd0 : stall_cnt_q;
    flushCnt_o   = rst ? 32'd0 : flush_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      resume_q    <= RUN;
      wait_cnt_q  <= 8'd0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      resume_q    <= resume_d;
      wait_cnt_q  <= wait_cnt_d;
      timeout_q   <= timeout_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipeline_scheduler.sv
// Scoreboard bench for pipeline_scheduler: the driver pushes hand-computed expectations
// per cycle, a negedge monitor pops and compares them against the DUT outputs.
module tb_pipeline_scheduler;

  logic        clk = 1'b0;
  logic        rst, PCSel_ei, memRead_ei, rs1Used_di, rs2Used_di, dmemReq_mi, dmemReady_i;
  logic [4:0]  rd_ei, rs1_di, rs2_di;
  logic        stall_F_o, stall_D_o, stall_E_o, stall_M_o, bubble_W_o;
  logic        flush_D_o, flush_E_o, memTimeout_o;
  logic [31:0] stallCnt_o, flushCnt_o;

  always #5 clk = ~clk;

  pipeline_scheduler dut (
    .clk(clk), .rst(rst), .PCSel_ei(PCSel_ei), .memRead_ei(memRead_ei), .rd_ei(rd_ei),
    .rs1_di(rs1_di), .rs2_di(rs2_di), .rs1Used_di(rs1Used_di), .rs2Used_di(rs2Used_di),
    .dmemReq_mi(dmemReq_mi), .dmemReady_i(dmemReady_i),
    .stall_F_o(stall_F_o), .stall_D_o(stall_D_o), .stall_E_o(stall_E_o), .stall_M_o(stall_M_o),
    .bubble_W_o(bubble_W_o), .flush_D_o(flush_D_o), .flush_E_o(flush_E_o),
    .memTimeout_o(memTimeout_o), .stallCnt_o(stallCnt_o), .flushCnt_o(flushCnt_o)
  );

  typedef struct {
    int          id;
    logic [3:0]  st;   // {F,D,E,M}
    logic        bub;
    logic        fd;
    logic        fe;
    logic [1:0]  tmo;  // 2 = not checked
    logic [31:0] sc;
    logic [31:0] fc;
  } exp_t;

  exp_t exp_q[$];
  int   ntests = 0;
  int   nfail  = 0;
  int   step_id = 0;

  task automatic chk(input int id, input string nm, input logic [31:0] act, input logic [31:0] req);
    ntests++;
    if (act !== req) begin
      nfail++;
      $display("[TB] FAIL step%0d %s: got 0x%0h expected 0x%0h", id, nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk(e.id, "stall_FDEM", {28'd0, stall_F_o, stall_D_o, stall_E_o, stall_M_o}, {28'd0, e.st});
      chk(e.id, "bubble_W", {31'd0, bubble_W_o}, {31'd0, e.bub});
      chk(e.id, "flush_D", {31'd0, flush_D_o}, {31'd0, e.fd});
      chk(e.id, "flush_E", {31'd0, flush_E_o}, {31'd0, e.fe});
      if (e.tmo != 2'd2) chk(e.id, "memTimeout", {31'd0, memTimeout_o}, {31'd0, e.tmo[0]});
      chk(e.id, "stallCnt", stallCnt_o, e.sc);
      chk(e.id, "flushCnt", flushCnt_o, e.fc);
      $display("[TB] step%0d st=%b bub=%b fD=%b fE=%b tmo=%b sc=%0d fc=%0d", e.id,
               {stall_F_o, stall_D_o, stall_E_o, stall_M_o}, bubble_W_o, flush_D_o, flush_E_o,
               memTimeout_o, stallCnt_o, flushCnt_o);
    end
  end

  // Inputs: r pc mr rd rs1 rs2 u1 u2 req rdy ; expected: st bub fd fe tmo sc fc
  task automatic step(input logic r, input logic pc, input logic mr, input logic [4:0] rd,
                      input logic [4:0] s1, input logic [4:0] s2, input logic u1, input logic u2,
                      input logic rq, input logic rdy,
                      input logic [3:0] st, input logic bub, input logic fd, input logic fe,
                      input logic [1:0] tmo, input logic [31:0] sc, input logic [31:0] fc);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; PCSel_ei = pc; memRead_ei = mr; rd_ei = rd; rs1_di = s1; rs2_di = s2;
    rs1Used_di = u1; rs2Used_di = u2; dmemReq_mi = rq; dmemReady_i = rdy;
    step_id++;
    e.id = step_id; e.st = st; e.bub = bub; e.fd = fd; e.fe = fe; e.tmo = tmo; e.sc = sc; e.fc = fc;
    exp_q.push_back(e);
  endtask

  task automatic idle(input logic [3:0] st, input logic fd, input logic [1:0] tmo,
                      input logic [31:0] sc, input logic [31:0] fc);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, st, 1'b0, fd, 1'b0, tmo, sc, fc);
  endtask

  task automatic memstall(input logic [1:0] tmo, input logic [31:0] sc, input logic [31:0] fc);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 4'hF, 1'b1, 1'b0, 1'b0, tmo, sc, fc);
  endtask

  initial begin
    rst = 1; PCSel_ei = 0; memRead_ei = 0; rd_ei = 0; rs1_di = 0; rs2_di = 0;
    rs1Used_di = 0; rs2Used_di = 0; dmemReq_mi = 0; dmemReady_i = 0;

    // Reset overrides a pending branch, stall and load-use
    step(1, 1, 1, 5, 5, 0, 1, 0, 1, 0, 4'h0, 0, 1, 1, 0, 0, 0);
    step(1, 1, 1, 5, 5, 0, 1, 0, 1, 0, 4'h0, 0, 1, 1, 0, 0, 0);
    idle(4'h0, 0, 0, 0, 0);

    // Load-use via rs1, then via rs2
    step(0, 0, 1, 5, 5, 0, 1, 0, 0, 0, 4'b1100, 0, 0, 1, 0, 0, 0);
    idle(4'h0, 0, 0, 1, 0);
    step(0, 0, 1, 7, 3, 7, 0, 1, 0, 0, 4'b1100, 0, 0, 1, 0, 1, 0);
    idle(4'h0, 0, 0, 2, 0);
    // x0 destination, unused source, non-load: no hazard
    step(0, 0, 1, 0, 0, 0, 1, 1, 0, 0, 4'h0, 0, 0, 0, 0, 2, 0);
    step(0, 0, 1, 5, 5, 5, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 2, 0);
    step(0, 0, 0, 5, 5, 5, 1, 1, 0, 0, 4'h0, 0, 0, 0, 0, 2, 0);

    // Taken branch with load-use inputs present (ignored), then REDIRECT ignores it too
    step(0, 1, 1, 5, 5, 0, 1, 0, 0, 0, 4'h0, 0, 1, 1, 0, 2, 0);
    step(0, 0, 1, 5, 5, 0, 1, 0, 0, 0, 4'h0, 0, 1, 0, 0, 2, 1);
    idle(4'h0, 0, 0, 2, 1);

    // Back-to-back branches re-enter REDIRECT
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 1, 1, 0, 2, 1);
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 1, 1, 0, 2, 2);
    idle(4'h0, 1, 0, 2, 3);
    idle(4'h0, 0, 0, 2, 3);

    // Memory wait for 3 cycles; branch/load-use during the stall are masked
    memstall(0, 2, 3);
    step(0, 1, 1, 5, 5, 0, 1, 0, 1, 0, 4'hF, 1, 0, 0, 0, 3, 3);
    memstall(0, 4, 3);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 4'h0, 0, 0, 0, 0, 5, 3);
    idle(4'h0, 0, 0, 5, 3);

    // Branch then stall: squash deferred to the first unstalled cycle
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 1, 1, 0, 5, 3);
    memstall(0, 5, 4);
    memstall(0, 6, 4);
    idle(4'h0, 1, 0, 7, 4);
    idle(4'h0, 0, 0, 7, 4);

    // Load-use on the release cycle of a wait from RUN
    memstall(0, 7, 4);
    step(0, 0, 1, 9, 0, 9, 0, 1, 0, 0, 4'b1100, 0, 0, 1, 0, 8, 4);
    idle(4'h0, 0, 0, 9, 4);

    // Timeout: 260 stall cycles; flag sticky afterwards
    for (int k = 1; k <= 260; k++) begin
      logic [1:0] t;
      t = (k <= 250) ? 2'd0 : (k >= 259) ? 2'd1 : 2'd2;
      memstall(t, 32'(9 + k - 1), 4);
    end
    idle(4'h0, 0, 1, 269, 4);
    idle(4'h0, 0, 1, 269, 4);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 1, 1, 0, 0, 0);
    idle(4'h0, 0, 0, 0, 0);

    // Reset mid-REDIRECT-deferred-wait abandons everything
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 1, 1, 0, 0, 0);
    memstall(0, 0, 1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 4'h0, 0, 1, 1, 0, 0, 0);
    idle(4'h0, 0, 0, 0, 0);
    idle(4'h0, 0, 0, 0, 0);

    @(posedge clk);
    #2;
    ntests++;
    if (exp_q.size() != 0) begin
      nfail++;
      $display("[TB] FAIL scoreboard_drain: %0d left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
